rp_gpio_bridge: RTL and testbench

//   Parametrised RP2040->iCE40 GPIO bridge for pico-ice designs.
//   - Synchronises N_CH asynchronous RP2040 pins and debounces each one.
//   - Reports per-channel debounced levels and rising-edge pulses.
//   - Drives active-low RGB/status LEDs and one registered logic-combine output to the RP2040.
//   - Sits between the top-level pins and user logic.

---
 rtl/rp_gpio_bridge.sv | 102 ++++++++++
 tb/tb_rp_gpio_bridge.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rp_gpio_bridge.sv
// RP2040 -> iCE40 GPIO bridge: per-channel synchroniser, debouncer, rise pulses,
// active-low LED drive and a registered logic-combine output. Optional LED PWM via GPIO_BRIDGE_PWM_EN.
module rp_gpio_bridge #(
  parameter int N_CH        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 16,
  parameter int PWM_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       gpio_in,
  input  logic [DEBOUNCE_W-1:0] debounce_limit,
  input  logic [1:0]            logic_mode,
`ifdef GPIO_BRIDGE_PWM_EN
  input  logic [PWM_W-1:0]      led_duty,
`endif
  output logic [N_CH-1:0]       level_out,
  output logic [N_CH-1:0]       rise_pulse,
  output logic [N_CH-1:0]       led_n,
  output logic                  logic_out
);

  logic [N_CH-1:0]       sync_q [SYNC_STAGES];
  logic [N_CH-1:0]       s;
  logic [N_CH-1:0]       level_q;
  logic [N_CH-1:0]       level_d;
  logic [N_CH-1:0]       rise_q;
  logic [DEBOUNCE_W-1:0] cnt_q [N_CH];
  logic [DEBOUNCE_W-1:0] cnt_d [N_CH];
  logic                  logic_q;
  logic                  logic_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // >= rather than == so a limit lowered mid-count commits on the next edge.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i] + 1'b1;
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= debounce_limit) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
      end
    end
  end

  always_comb begin
    logic_d = 1'b0;
    case (logic_mode)
      2'd0:    logic_d = &level_q;
      2'd1:    logic_d = |level_q;
      2'd2:    logic_d = ^level_q;
      default: logic_d = ~&level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      level_q <= '0;
      rise_q  <= '0;
      logic_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      logic_q <= logic_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign logic_out  = logic_q;

`ifdef GPIO_BRIDGE_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic             pwm_on;

  always_ff @(posedge clock) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_on = (pwm_cnt < led_duty);
  assign led_n  = ~(level_q & {N_CH{pwm_on}});
`else
  localparam int unused_pwm_w = PWM_W;
  assign led_n = ~level_q;
`endif

endmodule

// File: tb/tb_rp_gpio_bridge.sv
// Directed bench for rp_gpio_bridge (N_CH=3, SYNC_STAGES=2); PWM scenario only when GPIO_BRIDGE_PWM_EN is defined.
module tb_rp_gpio_bridge;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  gpio_in = 3'b111;
  logic [15:0] debounce_limit = 16'd4;
  logic [1:0]  logic_mode = 2'd0;
  logic [2:0]  level_out;
  logic [2:0]  rise_pulse;
  logic [2:0]  led_n;
  logic        logic_out;
`ifdef GPIO_BRIDGE_PWM_EN
  logic [3:0]  led_duty = 4'd0;
`endif

  int total = 0;
  int bad = 0;

  rp_gpio_bridge #(
    .N_CH(3), .SYNC_STAGES(2), .DEBOUNCE_W(16), .PWM_W(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .gpio_in(gpio_in),
    .debounce_limit(debounce_limit),
    .logic_mode(logic_mode),
`ifdef GPIO_BRIDGE_PWM_EN
    .led_duty(led_duty),
`endif
    .level_out(level_out),
    .rise_pulse(rise_pulse),
    .led_n(led_n),
    .logic_out(logic_out)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle; inputs written after this land before the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; gpio_in = 3'b111; logic_mode = 2'd3;
    repeat (3) tick();
    total++; if (level_out !== 3'b000) begin bad++; $display("FAIL reset_level got=%b want=000", level_out); end
    total++; if (rise_pulse !== 3'b000) begin bad++; $display("FAIL reset_rise got=%b want=000", rise_pulse); end
    total++; if (logic_out !== 1'b0) begin bad++; $display("FAIL reset_logic got=%b want=0", logic_out); end
    total++; if (led_n !== 3'b111) begin bad++; $display("FAIL reset_led got=%b want=111", led_n); end
    gpio_in = 3'b000;
    reset_n = 1'b1;
    tick();
    total++; if (logic_out !== 1'b1) begin bad++; $display("FAIL release_nand got=%b want=1", logic_out); end
    total++; if (rise_pulse !== 3'b000) begin bad++; $display("FAIL release_rise got=%b want=000", rise_pulse); end
    logic_mode = 2'd0;
    repeat (4) tick();
    total++; if (logic_out !== 1'b0) begin bad++; $display("FAIL idle_and got=%b want=0", logic_out); end
  endtask

  task automatic test_debounce();
    debounce_limit = 16'd4;
    gpio_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (level_out[0] !== (k >= 7)) begin bad++; $display("FAIL deb_level k=%0d got=%b want=%b", k, level_out[0], (k >= 7)); end
      total++; if (rise_pulse[0] !== (k == 7)) begin bad++; $display("FAIL deb_rise k=%0d got=%b want=%b", k, rise_pulse[0], (k == 7)); end
    end
`ifndef GPIO_BRIDGE_PWM_EN
    total++; if (led_n !== 3'b110) begin bad++; $display("FAIL deb_led got=%b want=110", led_n); end
`endif
  endtask

  task automatic test_glitch();
    debounce_limit = 16'd4;
    gpio_in[1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 4) gpio_in[1] = 1'b0;
      tick();
      total++; if (level_out[1] !== 1'b0) begin bad++; $display("FAIL glitch_level k=%0d got=%b want=0", k, level_out[1]); end
      total++; if (rise_pulse[1] !== 1'b0) begin bad++; $display("FAIL glitch_rise k=%0d got=%b want=0", k, rise_pulse[1]); end
      total++; if (led_n[1] !== 1'b1) begin bad++; $display("FAIL glitch_led k=%0d got=%b want=1", k, led_n[1]); end
    end
  endtask

  task automatic test_logic_modes();
    debounce_limit = 16'd0;
    gpio_in = 3'b101;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (level_out[2] !== (k == 3)) begin bad++; $display("FAIL lim0_level k=%0d got=%b want=%b", k, level_out[2], (k == 3)); end
    end
    tick();
    total++; if (level_out !== 3'b101) begin bad++; $display("FAIL lm_levels got=%b want=101", level_out); end
    total++; if (logic_out !== 1'b0) begin bad++; $display("FAIL lm_and got=%b want=0", logic_out); end
`ifndef GPIO_BRIDGE_PWM_EN
    total++; if (led_n !== 3'b010) begin bad++; $display("FAIL lm_led got=%b want=010", led_n); end
`endif
    logic_mode = 2'd1;
    total++; if (logic_out !== 1'b0) begin bad++; $display("FAIL lm_or_early got=%b want=0", logic_out); end
    tick();
    total++; if (logic_out !== 1'b1) begin bad++; $display("FAIL lm_or got=%b want=1", logic_out); end
    logic_mode = 2'd2;
    total++; if (logic_out !== 1'b1) begin bad++; $display("FAIL lm_xor_early got=%b want=1", logic_out); end
    tick();
    total++; if (logic_out !== 1'b0) begin bad++; $display("FAIL lm_xor got=%b want=0", logic_out); end
    logic_mode = 2'd3;
    total++; if (logic_out !== 1'b0) begin bad++; $display("FAIL lm_nand_early got=%b want=0", logic_out); end
    tick();
    total++; if (logic_out !== 1'b1) begin bad++; $display("FAIL lm_nand got=%b want=1", logic_out); end
    logic_mode = 2'd0;
    tick();
  endtask

  task automatic test_pwm();
`ifdef GPIO_BRIDGE_PWM_EN
    int lit;
    led_duty = 4'd4;
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (led_n[2] === 1'b0) lit++;
      total++; if (led_n[1] !== 1'b1) begin bad++; $display("FAIL pwm_off_ch k=%0d got=%b want=1", k, led_n[1]); end
    end
    total++; if (lit !== 4) begin bad++; $display("FAIL pwm_duty4 got=%0d want=4", lit); end
    led_duty = 4'd0;
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (led_n[2] === 1'b0) lit++;
    end
    total++; if (lit !== 0) begin bad++; $display("FAIL pwm_duty0 got=%0d want=0", lit); end
`endif
  endtask

  task automatic test_mid_count();
    debounce_limit = 16'd10;
    gpio_in[1] = 1'b1;
    repeat (7) tick();
    total++; if (level_out[1] !== 1'b0) begin bad++; $display("FAIL mid_before got=%b want=0", level_out[1]); end
    debounce_limit = 16'd2;
    tick();
    total++; if (level_out[1] !== 1'b1) begin bad++; $display("FAIL mid_commit got=%b want=1", level_out[1]); end
    total++; if (rise_pulse[1] !== 1'b1) begin bad++; $display("FAIL mid_rise got=%b want=1", rise_pulse[1]); end

    reset_n = 1'b0; gpio_in = 3'b000; debounce_limit = 16'd10;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    total++; if (level_out !== 3'b000) begin bad++; $display("FAIL rst_clear got=%b want=000", level_out); end
    gpio_in[0] = 1'b1;
    repeat (7) tick();
    reset_n = 1'b0;
    tick();
    total++; if (level_out !== 3'b000) begin bad++; $display("FAIL rst_mid got=%b want=000", level_out); end
    reset_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      total++; if (level_out[0] !== (k == 13)) begin bad++; $display("FAIL rst_discard k=%0d got=%b want=%b", k, level_out[0], (k == 13)); end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_logic_modes();
    test_pwm();
    test_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
